adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//   Shares one RCA adder instance (SIZE=WIDTH) among NUM_REQ requesters.
//   Round-robin grant, valid/ready handshake on each request port, registered result.
//   Single response port tagged with the requester id.
//   Sits between ALU issue logic and the adder datapath; the only owner of the adder.
// PARAMETERS
//   WIDTH    8  operand width; adder result is WIDTH+1 bits
//   NUM_REQ  4  number of requesters, >=2
//   ID_W     $clog2(NUM_REQ)  width of requester id (derived, do not override)
// PORTS
//   clk          in   1                clock, all state on rising edge
//   rst          in   1                synchronous reset, active-high
//   req_valid    in   NUM_REQ          per-requester request valid
//   req_ready    out  NUM_REQ          per-requester accept; at most one bit set
//   req_a        in   NUM_REQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   NUM_REQ*WIDTH    operand B, same packing
//   rsp_valid    out  1                response valid
//   rsp_ready    in   1                response accept from consumer
//   rsp_id       out  ID_W             id of requester that owns this response
//   rsp_result   out  WIDTH+1          a+b, bit WIDTH is carry out
//   rsp_overflow out  1                equals rsp_result[WIDTH]
// BEHAVIOUR
//   Clock/reset: one clock clk; reset rst is synchronous and active-high.
//   Reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0,
//     req_ready=0, operand regs=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first).
//   FSM: IDLE -> ADD -> RESP -> IDLE.
//   IDLE:
//     grant g = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//     req_ready[g]=1 combinationally; all other req_ready bits are 0.
//     No req_valid set: stay in IDLE, req_ready=0.
//     On accept, latch req_a[g], req_b[g] into op_a/op_b, g into id_q; go to ADD.
//   ADD:
//     req_ready=0; op_a/op_b drive the adder.
//     Register result into rsp_result/rsp_overflow, id_q into rsp_id; set rsp_valid=1; go to RESP.
//   RESP:
//     rsp_valid=1; rsp_id/rsp_result/rsp_overflow held stable until handshake.
//     On rsp_valid&rsp_ready: rsp_valid<=0, rr_ptr<=id_q, go to IDLE.
//     rsp_ready low: stay, no new grant (req_ready=0).
//   Latency: accept in cycle T -> rsp_valid high in cycle T+2.
//     Best-case throughput is one op per 3 cycles.
//   Arithmetic: unsigned WIDTH+1-bit sum; no saturation or wrap. rsp_overflow=carry out.
//   Requester rules:
//     Must hold req_valid and operands stable until its req_ready.
//     The arbiter samples operands only in the accept cycle.
//   Fairness:
//     A requester that holds req_valid is granted within NUM_REQ grants.
//     rr_ptr wraps NUM_REQ-1 -> 0.
//   Simultaneous events:
//     req_valid changes during ADD/RESP are ignored until IDLE.
//     rsp_ready high in ADD has no effect.
//   Reset mid-operation: rst in any state forces reset values next edge.
//     An in-flight op is dropped with no response.
// TESTING
//   1 Reset: hold rst 2 cycles -> rsp_valid=0, req_ready=0; then req_valid=4'b0001 -> req_ready=4'b0001 same cycle.
//   2 Req0 a=0x7F b=0x01, rsp_ready=1 -> T+2: rsp_valid=1, rsp_id=0, rsp_result=0x080, rsp_overflow=0.
//   3 Req2 a=0xFF b=0x01 -> rsp_id=2, rsp_result=0x100, rsp_overflow=1.
//   4 req_valid=4'b1111 held from reset, rsp_ready=1 -> grant order 0,1,2,3,0; one grant every 3 cycles.
//   5 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; release -> IDLE next cycle.
//   6 rst asserted in ADD -> next cycle rsp_valid=0, state IDLE; next grant goes to requester 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters.
// Each operation takes IDLE (accept) -> ADD -> RESP and returns a registered, id-tagged result.
module adder_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_result,
  output logic                     rsp_overflow
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [WIDTH:0]    sum;
  logic              carry;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found)
      req_ready[gnt_id] = 1'b1;
  end

  // The shared adder: a plain ripple-carry chain over the latched operands.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = op_a[i] ^ op_b[i] ^ carry;
      carry  = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
    end
    sum[WIDTH] = carry;
  end

  assign rsp_overflow = rsp_result[WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_a  <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
            op_b  <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
            id_q  <= gnt_id;
            state <= ADD;
          end
        end
        ADD: begin
          rsp_result <= sum;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= id_q;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed literal checks plus a transaction-level model
// compared against the DUT on every cycle under randomized traffic.
module tb_adder_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [1:0]       rsp_id;
  logic [W:0]       rsp_result;
  logic             rsp_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a single op in flight, result visible from the
  // second cycle after accept until the consumer takes it.
  bit        m_on   = 1'b0;
  bit        m_busy = 1'b0;
  int        m_age  = 0;
  int        m_last = N - 1;
  int        m_id   = 0;
  int        m_sum  = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           g;
    int           i;
    bit           exp_valid;
    if (rst) begin
      m_on   = 1'b1;
      m_busy = 1'b0;
      m_age  = 0;
      m_last = N - 1;
    end else if (m_on) begin
      exp_ready = '0;
      g         = -1;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          i = (m_last + k) % N;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_valid = m_busy && (m_age >= 1);
      check("model req_ready", 32'(req_ready), 32'(exp_ready));
      check("model rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("model rsp_id", 32'(rsp_id), m_id);
        check("model rsp_result", 32'(rsp_result), m_sum);
        check("model rsp_overflow", 32'(rsp_overflow), 32'(m_sum >= (1 << W)));
      end
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = g;
        m_sum  = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
      end else if (m_busy) begin
        if (m_age >= 1 && rsp_ready) begin
          m_busy = 1'b0;
          m_last = m_id;
        end else begin
          m_age++;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] acc;
    int           gnt_id[$];
    int           gnt_cyc[$];
    int           idx;

    // Reset held two cycles.
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset req_ready", 32'(req_ready), 0);
    check("reset rsp_id", 32'(rsp_id), 0);
    check("reset rsp_result", 32'(rsp_result), 0);
    check("reset rsp_overflow", 32'(rsp_overflow), 0);

    // Requester 0: 0x7F + 0x01.
    cyc();
    req_valid = 4'b0001; req_a[0 +: W] = 8'h7F; req_b[0 +: W] = 8'h01;
    @(negedge clk);
    check("req0 ready same cycle", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("req0 T+1 no rsp", 32'(rsp_valid), 0);
    cyc();
    @(negedge clk);
    check("req0 T+2 rsp_valid", 32'(rsp_valid), 1);
    check("req0 rsp_id", 32'(rsp_id), 0);
    check("req0 rsp_result", 32'(rsp_result), 32'h080);
    check("req0 rsp_overflow", 32'(rsp_overflow), 0);

    // Requester 2: 0xFF + 0x01 carries out.
    cyc();
    req_valid = 4'b0100; req_a[2*W +: W] = 8'hFF; req_b[2*W +: W] = 8'h01;
    @(negedge clk);
    check("req2 ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    check("req2 rsp_id", 32'(rsp_id), 2);
    check("req2 rsp_result", 32'(rsp_result), 32'h100);
    check("req2 rsp_overflow", 32'(rsp_overflow), 1);

    // Backpressure: five RESP cycles with rsp_ready low.
    cyc();
    req_valid = 4'b0001; req_a[0 +: W] = 8'h12; req_b[0 +: W] = 8'h34; rsp_ready = 1'b0;
    @(negedge clk);
    check("bp wrap grant to 0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b1111;
    @(negedge clk);
    check("bp ADD no grant", 32'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 4) rsp_ready = 1'b1;
      @(negedge clk);
      check("bp rsp_valid held", 32'(rsp_valid), 1);
      check("bp rsp_result held", 32'(rsp_result), 32'h046);
      check("bp rsp_id held", 32'(rsp_id), 0);
      check("bp no grant", 32'(req_ready), 0);
    end
    cyc();
    @(negedge clk);
    check("bp release rsp_valid", 32'(rsp_valid), 0);
    check("bp release next grant", 32'(req_ready), 32'h2);

    // Reset during ADD drops the op; requester 0 wins next.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst in ADD rsp_valid", 32'(rsp_valid), 0);
    check("rst in ADD grant 0", 32'(req_ready), 32'h1);

    // All requesters valid from reset: grants 0,1,2,3,0 every 3 cycles.
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        idx = -1;
        for (int j = 0; j < N; j++) if (req_ready[j]) idx = j;
        gnt_id.push_back(idx);
        gnt_cyc.push_back(k);
      end
      cyc();
    end
    check("rr grant count", gnt_id.size(), 5);
    for (int k = 0; k < 5 && k < gnt_id.size(); k++) begin
      check("rr grant id", gnt_id[k], k % N);
      check("rr grant cycle", gnt_cyc[k], 3 * k);
    end

    // Randomized traffic; requesters hold request until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready & {N{~rst}};
      cyc();
      for (int j = 0; j < N; j++) begin
        if (!req_valid[j] || acc[j]) begin
          req_valid[j] = 1'($urandom_range(0, 1));
          req_a[j*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
          req_b[j*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
